fetch_redirect_ctrl: RTL and testbench

- Producer side of the fetch PC-select interface: collects redirect requests from the back end (eret, exception/interrupt, resolved taken branch) and drives the one-hot redirect inputs of the fetch PC multiplexer.
- Registers each request and holds it until fetch accepts it.
- Enforces the MIPS delay-slot rule: if a branch resolves before its delay slot has been fetched, it issues a slot redirect first, then the branch target.
- Sits between the execute/commit stages and the fetch PC register.

---
 rtl/fetch_redirect_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Redirect request collector for the fetch PC mux: latches eret, exception and
// branch redirects, orders delay-slot before target, and holds each until fetch accepts it.
module fetch_redirect_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int WAITC_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               eret_req,
    input  logic [ADDR_W-1:0]  epc_in,
    input  logic               exc_req,
    input  logic [ADDR_W-1:0]  entrance_in,
    input  logic               br_req,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               br_slot_fetched,
    input  logic [ADDR_W-1:0]  br_slot_pc,
    input  logic               fetch_ready,
    output logic               is_eret,
    output logic [ADDR_W-1:0]  epc,
    output logic               is_INTEXC,
    output logic [ADDR_W-1:0]  entrance,
    output logic               branch_taken,
    output logic [ADDR_W-1:0]  pc_branch,
    output logic               select_slot,
    output logic [ADDR_W-1:0]  slot_pc,
    output logic               redir_busy,
    output logic [WAITC_W-1:0] wait_cycles
);

    // state | meaning
    // IDLE  | no redirect pending
    // ERET  | eret return address offered to fetch
    // EXC   | exception vector offered to fetch
    // SLOT  | delay-slot PC offered; branch target follows on acceptance
    // TGT   | branch target offered to fetch
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERET = 3'd1,
        S_EXC  = 3'd2,
        S_SLOT = 3'd3,
        S_TGT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   epc_q, epc_d;
    logic [ADDR_W-1:0]   entrance_q, entrance_d;
    logic [ADDR_W-1:0]   pc_branch_q, pc_branch_d;
    logic [ADDR_W-1:0]   slot_pc_q, slot_pc_d;
    logic [WAITC_W-1:0]  wait_q, wait_d;
    logic                busy;
    logic                accept;

    assign busy   = (state_q != S_IDLE);
    assign accept = busy & fetch_ready;

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        entrance_d  = entrance_q;
        pc_branch_d = pc_branch_q;
        slot_pc_d   = slot_pc_q;
        wait_d      = wait_q;
        // A fresh capture always wins over acceptance of the pending redirect.
        if (eret_req) begin
            state_d = S_ERET;
            epc_d   = epc_in;
            wait_d  = '0;
        end else if (exc_req) begin
            state_d    = S_EXC;
            entrance_d = entrance_in;
            wait_d     = '0;
        end else if (!busy && br_req) begin
            state_d     = br_slot_fetched ? S_TGT : S_SLOT;
            pc_branch_d = br_target;
            slot_pc_d   = br_slot_pc;
            wait_d      = '0;
        end else if (accept) begin
            state_d = (state_q == S_SLOT) ? S_TGT : S_IDLE;
            wait_d  = '0;
        end else if (busy && (wait_q != {WAITC_W{1'b1}})) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            epc_q       <= '0;
            entrance_q  <= '0;
            pc_branch_q <= '0;
            slot_pc_q   <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            epc_q       <= epc_d;
            entrance_q  <= entrance_d;
            pc_branch_q <= pc_branch_d;
            slot_pc_q   <= slot_pc_d;
            wait_q      <= wait_d;
        end
    end

    assign is_eret      = (state_q == S_ERET);
    assign is_INTEXC    = (state_q == S_EXC);
    assign select_slot  = (state_q == S_SLOT);
    assign branch_taken = (state_q == S_TGT);
    assign redir_busy   = busy;
    assign epc          = epc_q;
    assign entrance     = entrance_q;
    assign pc_branch    = pc_branch_q;
    assign slot_pc      = slot_pc_q;
    assign wait_cycles  = wait_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: a queue-of-pending-redirects model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_redirect_ctrl;

    localparam int ADDR_W  = 32;
    localparam int WAITC_W = 8;
    localparam int WSAT    = (1 << WAITC_W) - 1;

    localparam int K_ERET = 1;
    localparam int K_EXC  = 2;
    localparam int K_SLOT = 3;
    localparam int K_TGT  = 4;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn = 1'b0;
    logic              eret_req = 1'b0, exc_req = 1'b0, br_req = 1'b0;
    logic              br_slot_fetched = 1'b0, fetch_ready = 1'b0;
    logic [ADDR_W-1:0] epc_in = '0, entrance_in = '0, br_target = '0, br_slot_pc = '0;

    logic               is_eret, is_INTEXC, branch_taken, select_slot, redir_busy;
    logic [ADDR_W-1:0]  epc, entrance, pc_branch, slot_pc;
    logic [WAITC_W-1:0] wait_cycles;

    fetch_redirect_ctrl #(.ADDR_W(ADDR_W), .WAITC_W(WAITC_W)) dut (
        .clk(clk), .resetn(resetn),
        .eret_req(eret_req), .epc_in(epc_in),
        .exc_req(exc_req), .entrance_in(entrance_in),
        .br_req(br_req), .br_target(br_target),
        .br_slot_fetched(br_slot_fetched), .br_slot_pc(br_slot_pc),
        .fetch_ready(fetch_ready),
        .is_eret(is_eret), .epc(epc),
        .is_INTEXC(is_INTEXC), .entrance(entrance),
        .branch_taken(branch_taken), .pc_branch(pc_branch),
        .select_slot(select_slot), .slot_pc(slot_pc),
        .redir_busy(redir_busy), .wait_cycles(wait_cycles)
    );

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the redirects still owed to fetch, in issue order.
    int          pend[$];
    logic [31:0] m_epc = 0, m_ent = 0, m_pcb = 0, m_slot = 0;
    int          m_wait = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend.delete();
            m_epc = 0; m_ent = 0; m_pcb = 0; m_slot = 0; m_wait = 0;
        end else if (eret_req) begin
            pend.delete(); pend.push_back(K_ERET); m_epc = epc_in; m_wait = 0;
        end else if (exc_req) begin
            pend.delete(); pend.push_back(K_EXC); m_ent = entrance_in; m_wait = 0;
        end else if (pend.size() == 0 && br_req) begin
            m_pcb = br_target; m_slot = br_slot_pc; m_wait = 0;
            if (!br_slot_fetched) pend.push_back(K_SLOT);
            pend.push_back(K_TGT);
        end else if (pend.size() != 0 && fetch_ready) begin
            void'(pend.pop_front());
            m_wait = 0;
        end else if (pend.size() != 0) begin
            m_wait = (m_wait < WSAT) ? m_wait + 1 : WSAT;
        end
    end

    function automatic int front();
        return (pend.size() != 0) ? pend[0] : 0;
    endfunction

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_is_eret",      32'(is_eret),      32'(front() == K_ERET));
            check("m_is_INTEXC",    32'(is_INTEXC),    32'(front() == K_EXC));
            check("m_select_slot",  32'(select_slot),  32'(front() == K_SLOT));
            check("m_branch_taken", 32'(branch_taken), 32'(front() == K_TGT));
            check("m_redir_busy",   32'(redir_busy),   32'(pend.size() != 0));
            check("m_epc",          epc,               m_epc);
            check("m_entrance",     entrance,          m_ent);
            check("m_pc_branch",    pc_branch,         m_pcb);
            check("m_slot_pc",      slot_pc,           m_slot);
            check("m_wait_cycles",  32'(wait_cycles),  32'(m_wait));
        end
    end

    task automatic idle_in();
        eret_req = 0; exc_req = 0; br_req = 0;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_flags"}, {27'b0, is_eret, is_INTEXC, select_slot, branch_taken, redir_busy}, 32'h0);
        check({tag, "_addr"}, epc | entrance | pc_branch | slot_pc, 32'h0);
        check({tag, "_wait"}, 32'(wait_cycles), 32'h0);
    endtask

    initial begin
        // Reset with stimulus active.
        br_req = 1; br_target = 32'h8000_1000; br_slot_fetched = 1; fetch_ready = 1;
        epc_in = 32'h1234_5678; eret_req = 0;
        repeat (3) @(negedge clk);
        all_zero("reset");
        resetn = 1;
        chk_en = 1;

        // Branch with slot already fetched.
        @(negedge clk);
        check("br_taken", 32'(branch_taken), 32'h1);
        check("br_pc", pc_branch, 32'h8000_1000);
        idle_in();
        @(negedge clk);
        check("br_done", {30'b0, branch_taken, redir_busy}, 32'h0);

        // Branch with slot not yet fetched: slot, then target.
        br_req = 1; br_slot_fetched = 0; br_slot_pc = 32'h8000_0104; br_target = 32'h8000_2000;
        @(negedge clk);
        check("slot_sel", {30'b0, select_slot, branch_taken}, 32'h2);
        check("slot_pc", slot_pc, 32'h8000_0104);
        idle_in();
        @(negedge clk);
        check("slot_tgt", {30'b0, select_slot, branch_taken}, 32'h1);
        check("slot_tgt_pc", pc_branch, 32'h8000_2000);
        @(negedge clk);
        check("slot_idle", 32'(redir_busy), 32'h0);

        // Exception held while fetch stalls.
        exc_req = 1; entrance_in = 32'hBFC0_0380; fetch_ready = 0;
        @(negedge clk);
        check("exc_flag", 32'(is_INTEXC), 32'h1);
        check("exc_addr", entrance, 32'hBFC0_0380);
        idle_in();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("exc_wait", 32'(wait_cycles), 32'(i));
        end
        fetch_ready = 1;
        @(negedge clk);
        check("exc_clear", {30'b0, is_INTEXC, redir_busy}, 32'h0);

        // Exception overrides a pending slot; branch never issues.
        br_req = 1; br_slot_fetched = 0; fetch_ready = 0;
        @(negedge clk);
        idle_in(); exc_req = 1; entrance_in = 32'h8000_0180;
        @(negedge clk);
        check("ovr_flags", {28'b0, is_INTEXC, select_slot, branch_taken, is_eret}, 32'h8);
        idle_in(); fetch_ready = 1;
        repeat (2) begin
            @(negedge clk);
            check("ovr_nobr", {30'b0, branch_taken, redir_busy}, 32'h0);
        end

        // eret beats exception in the same cycle.
        eret_req = 1; exc_req = 1; epc_in = 32'h8000_0400;
        @(negedge clk);
        check("prio_flags", {30'b0, is_eret, is_INTEXC}, 32'h2);
        check("prio_epc", epc, 32'h8000_0400);
        idle_in();
        @(negedge clk);

        // br_req ignored while TGT pending; exception in the acceptance cycle.
        br_req = 1; br_slot_fetched = 1; br_target = 32'hA000_0000; fetch_ready = 0;
        @(negedge clk);
        br_target = 32'hB000_0000;
        @(negedge clk);
        check("ign_pcb", pc_branch, 32'hA000_0000);
        check("ign_tgt", 32'(branch_taken), 32'h1);
        br_req = 0; exc_req = 1; fetch_ready = 1;
        @(negedge clk);
        check("nogap_exc", {30'b0, is_INTEXC, redir_busy}, 32'h3);
        idle_in();
        @(negedge clk);

        // Asynchronous reset mid-exception.
        exc_req = 1; fetch_ready = 0;
        @(negedge clk);
        idle_in();
        #2 resetn = 0;
        #1 all_zero("async");
        @(negedge clk);
        resetn = 1;

        // Wait counter saturation.
        exc_req = 1; fetch_ready = 0;
        @(negedge clk);
        idle_in();
        repeat (300) @(negedge clk);
        check("sat_wait", 32'(wait_cycles), 32'd255);
        fetch_ready = 1;
        @(negedge clk);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            eret_req        = ($urandom_range(99) < 4);
            exc_req         = ($urandom_range(99) < 6);
            br_req          = ($urandom_range(99) < 35);
            br_slot_fetched = $urandom_range(1);
            fetch_ready     = ($urandom_range(99) < 55);
            epc_in          = $urandom;
            entrance_in     = $urandom;
            br_target       = $urandom;
            br_slot_pc      = $urandom;
            @(negedge clk);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
